regfile_dbg: RTL and testbench

REGFILE_DBG -- requirements
Module: regfile_dbg

---
 rtl/regfile_dbg.sv | 160 ++++++++++++++++
 tb/tb_regfile_dbg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dbg.sv
// Debug access port to the core register file: halts the core, performs one read or write,
// then returns a response. Optional auto-increment pointer enabled by REGFILE_DBG_AUTOINC_EN.
module regfile_dbg #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned HALT_TMO = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [4:0]      cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  input  logic            cmd_inc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            halt_req,
  input  logic            halt_ack,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [4:0]      rf_rs,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StHalt, StAccess, StResp} state_e;

  // Counter holds the number of HALT cycles already spent; timeout fires on the last allowed one.
  localparam logic [7:0] TmoLast = 8'(HALT_TMO - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [4:0]        addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [4:0]        eff_addr;

`ifdef REGFILE_DBG_AUTOINC_EN
  logic [4:0] ptr_q, ptr_d;

  assign eff_addr = cmd_inc ? ptr_q : cmd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StAccess) begin
      ptr_d = addr_q + 5'd1;
    end
  end
`else
  logic unused_cmd_inc;

  assign unused_cmd_inc = cmd_inc;
  assign eff_addr       = cmd_addr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state_q only, so an asynchronous reset drops them immediately.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    halt_req  = 1'b0;
    rf_we     = 1'b0;
    rf_rd     = '0;
    rf_wd     = '0;
    rf_rs     = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        cnt_d     = '0;
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = eff_addr;
          wdata_d = cmd_wdata;
          state_d = StHalt;
        end
      end
      StHalt: begin
        halt_req = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        if (halt_ack) begin
          state_d = StAccess;
        end else if (cnt_q == TmoLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StAccess: begin
        // halt_ack is deliberately not sampled here: the access is already committed.
        halt_req = 1'b1;
        if (write_q) begin
          rf_we   = (addr_q != 5'd0);
          rf_rd   = addr_q;
          rf_wd   = wdata_q;
          rdata_d = '0;
          err_d   = (addr_q == 5'd0);
        end else begin
          rf_rs   = addr_q;
          rdata_d = (addr_q == 5'd0) ? '0 : rf_rdata;
          err_d   = 1'b0;
        end
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_dbg.sv
// Directed self-checking bench for regfile_dbg with a behavioural register file model.
module tb_regfile_dbg;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_inc;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        halt_req, halt_ack;
  logic        rf_we;
  logic [4:0]  rf_rd, rf_rs;
  logic [31:0] rf_wd, rf_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [32];
  logic [31:0] written = '0;
  int          we_cnt  = 0;

  regfile_dbg #(.XLEN(32), .HALT_TMO(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_inc   (cmd_inc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .halt_req  (halt_req),
    .halt_ack  (halt_ack),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .rf_rs     (rf_rs),
    .rf_rdata  (rf_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] preset(input logic [4:0] idx);
    if (idx == 5'd5) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | {27'd0, idx};
  endfunction

  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_rd]     <= rf_wd;
      written[rf_rd] <= 1'b1;
      we_cnt         <= we_cnt + 1;
    end
  end

  always_comb rf_rdata = written[rf_rs] ? mem[rf_rs] : preset(rf_rs);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle; returns one tick after the accept edge (first HALT cycle).
  task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d, input logic inc);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_inc   = inc;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_inc   = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int bad;
    int we_base;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_inc   = 1'b0;
    rsp_ready = 1'b0;
    halt_ack  = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_halt_req", {31'd0, halt_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Read x5 with immediate ack: minimum latency path.
    halt_ack = 1'b1;
    issue(1'b0, 5'd5, 32'h0, 1'b0);
    chk("rd5_halt_req", {31'd0, halt_req}, 32'd1);
    chk("rd5_halt_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rd5_halt_busy", {31'd0, busy}, 32'd1);
    step();
    chk("rd5_acc_rf_rs", {27'd0, rf_rs}, 32'd5);
    chk("rd5_acc_halt_req", {31'd0, halt_req}, 32'd1);
    chk("rd5_acc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("rd5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd5_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd5_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rd5_rsp_halt_req", {31'd0, halt_req}, 32'd0);
    finish_rsp();
    chk("rd5_back_idle", {31'd0, cmd_ready}, 32'd1);
    chk("rd5_idle_rdata", rsp_rdata, 32'd0);

    // Write x0: rejected with error, no register write.
    we_base = we_cnt;
    issue(1'b1, 5'd0, 32'h1234_5678, 1'b0);
    chk("wr0_halt_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("wr0_acc_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("wr0_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("wr0_rsp_rdata", rsp_rdata, 32'd0);
    finish_rsp();
    chk("wr0_we_count", we_cnt - we_base, 32'd0);

    // Read x3 without ack: exactly 255 HALT cycles then timeout response.
    halt_ack = 1'b0;
    issue(1'b0, 5'd3, 32'h0, 1'b0);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      if (!halt_req || rsp_valid || rf_we || rf_rs != 5'd0) bad++;
      step();
    end
    chk("tmo_halt_cycles_clean", bad, 32'd0);
    chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tmo_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("tmo_rsp_rdata", rsp_rdata, 32'd0);
    finish_rsp();

    // Write x31 with a stalled response channel.
    halt_ack = 1'b1;
    we_base  = we_cnt;
    issue(1'b1, 5'd31, 32'hA5A5_A5A5, 1'b0);
    chk("wr31_halt_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("wr31_acc_we", {31'd0, rf_we}, 32'd1);
    chk("wr31_acc_rd", {27'd0, rf_rd}, 32'd31);
    chk("wr31_acc_wd", rf_wd, 32'hA5A5_A5A5);
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || cmd_ready || rf_we || rsp_err) bad++;
      step();
    end
    chk("wr31_rsp_hold", bad, 32'd0);
    chk("wr31_still_valid", {31'd0, rsp_valid}, 32'd1);
    finish_rsp();
    chk("wr31_we_pulses", we_cnt - we_base, 32'd1);
    chk("wr31_mem", mem[31], 32'hA5A5_A5A5);
    chk("wr31_idle", {31'd0, cmd_ready}, 32'd1);

    // Reset during the ACCESS of a write drops outputs asynchronously.
    issue(1'b1, 5'd7, 32'h7777_7777, 1'b0);
    step();
    chk("rstacc_we_before", {31'd0, rf_we}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstacc_we_async", {31'd0, rf_we}, 32'd0);
    chk("rstacc_halt_async", {31'd0, halt_req}, 32'd0);
    chk("rstacc_busy_async", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rstacc_busy_after", {31'd0, busy}, 32'd0);
    chk("rstacc_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("rstacc_no_write", {31'd0, written[7]}, 32'd0);

    // halt_ack dropping during ACCESS does not abort the read.
    issue(1'b0, 5'd5, 32'h0, 1'b0);
    step();
    halt_ack = 1'b0;
    step();
    chk("ackdrop_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ackdrop_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("ackdrop_err", {31'd0, rsp_err}, 32'd0);
    finish_rsp();
    halt_ack = 1'b1;

`ifdef REGFILE_DBG_AUTOINC_EN
    // Pointer follows the last access: 30, then 31, then wraps to 0.
    issue(1'b0, 5'd30, 32'h0, 1'b0);
    step();
    chk("inc_a_rs", {27'd0, rf_rs}, 32'd30);
    step();
    chk("inc_a_rdata", rsp_rdata, 32'hC0DE_001E);
    finish_rsp();
    issue(1'b0, 5'd9, 32'h0, 1'b1);
    step();
    chk("inc_b_rs", {27'd0, rf_rs}, 32'd31);
    step();
    chk("inc_b_rdata", rsp_rdata, 32'hA5A5_A5A5);
    finish_rsp();
    issue(1'b0, 5'd9, 32'h0, 1'b1);
    step();
    chk("inc_c_rs", {27'd0, rf_rs}, 32'd0);
    step();
    chk("inc_c_rdata", rsp_rdata, 32'd0);
    chk("inc_c_err", {31'd0, rsp_err}, 32'd0);
    finish_rsp();
`else
    // cmd_inc has no effect: cmd_addr is used as given.
    issue(1'b0, 5'd9, 32'h0, 1'b1);
    step();
    chk("noinc_rs", {27'd0, rf_rs}, 32'd9);
    step();
    chk("noinc_rdata", rsp_rdata, 32'hC0DE_0009);
    finish_rsp();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
